// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, I/D cache miss
// sequencing with line-fill pulses, HALT latch and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MISS_LATENCY = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             ID_Rs,
  input  logic [1:0]             ID_Rt,
  input  logic                   ID_UsesRs,
  input  logic                   ID_UsesRt,
  input  logic                   ID_IsHalted,
  input  logic                   ID_FlushReq,
  input  logic                   EX_MemRead,
  input  logic [1:0]             EX_WriteReg,
  input  logic                   IcacheReq,
  input  logic                   IcacheHit,
  input  logic                   DcacheReq,
  input  logic                   DcacheHit,
  output logic                   PcWrite,
  output logic                   IF_ID_Write,
  output logic                   InsertBubble,
  output logic                   IsFlush,
  output logic                   PipeFreeze,
  output logic                   FillI,
  output logic                   FillD,
  output logic                   Halted,
  output logic [STALL_CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {RUN, DMISS, IMISS, HALT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MISS_LATENCY - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   pend_i_q, pend_i_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic d_miss, i_miss, load_use;
  logic pc_write, if_id_write, bubble, flush, freeze, fill_i, fill_d;

  always_comb begin
    d_miss   = DcacheReq && !DcacheHit;
    i_miss   = IcacheReq && !IcacheHit;
    load_use = EX_MemRead && ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                              (ID_UsesRt && (ID_Rt == EX_WriteReg)));

    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_i_d    = pend_i_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    bubble      = 1'b0;
    flush       = 1'b0;
    freeze      = 1'b0;
    fill_i      = 1'b0;
    fill_d      = 1'b0;

    case (state_q)
      RUN: begin
        if (d_miss) begin
          // MEM cannot complete: freeze right away, overriding load-use/flush
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          freeze      = 1'b1;
          state_d     = DMISS;
          cnt_d       = CNT_LOAD;
          pend_i_d    = i_miss;
        end else begin
          if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
          end else if (ID_FlushReq) begin
            flush = 1'b1;
          end
          if (i_miss) begin
            state_d = IMISS;
            cnt_d   = CNT_LOAD;
          end else if (ID_IsHalted) begin
            state_d = HALT;
          end
        end
      end
      DMISS: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        freeze      = 1'b1;
        if (i_miss) pend_i_d = 1'b1;
        if (cnt_q == 4'd0) begin
          fill_d   = 1'b1;
          pend_i_d = 1'b0;
          if (pend_i_q || i_miss) begin
            state_d = IMISS;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      IMISS: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        bubble      = 1'b1;
        if (cnt_q == 4'd0) begin
          fill_i  = 1'b1;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HALT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        freeze      = 1'b1;
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (state_q != HALT) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      pend_i_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_i_q    <= pend_i_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are forced to their idle values while reset is held, independent of inputs
  always_comb begin
    PcWrite      = pc_write    || !reset_n;
    IF_ID_Write  = if_id_write || !reset_n;
    InsertBubble = bubble && reset_n;
    IsFlush      = flush  && reset_n;
    PipeFreeze   = freeze && reset_n;
    FillI        = fill_i && reset_n;
    FillD        = fill_d && reset_n;
    Halted       = (state_q == HALT) && reset_n;
    StallCount   = stall_cnt_q;
  end

endmodule
